// File: rtl/debouncer_multi_pkg.sv
// Shared debouncer defaults, reused by the timers block and the debouncer top level.
package debouncer_multi_pkg;

  localparam int unsigned DEBOUNCE_DEPTH_DEFAULT = 5;
  localparam int unsigned LONG_TICKS_DEFAULT     = 200;

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: input synchroniser, tick-sampled shift register, hysteretic level,
// rise/fall pulses and a saturating long-press counter.
module debounce_channel
  import debouncer_multi_pkg::*;
#(
  parameter int unsigned DEPTH       = DEBOUNCE_DEPTH_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LONG_TICKS  = LONG_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_tick,
  input  logic bouncing,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic long_held
);

  localparam int unsigned CountW = $clog2(LONG_TICKS + 1);
  localparam logic [CountW-1:0] LongMax = CountW'(LONG_TICKS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEPTH-1:0]       shift_q;
  logic                   level_q, level_d;
  logic                   rise_q, fall_q;
  logic                   press_q, press_d;
  logic                   held_q, held_d;
  logic [CountW-1:0]      count_q, count_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Mixed sample history holds the previous level.
  always_comb begin
    level_d = level_q;
    if (&shift_q) begin
      level_d = 1'b1;
    end else if (~|shift_q) begin
      level_d = 1'b0;
    end
  end

  // Counting needs level_q high as well, so the tick coinciding with the rise is skipped;
  // clearing follows level_d so held drops together with the fall pulse.
  always_comb begin
    count_d = count_q;
    press_d = 1'b0;
    if (!level_d) begin
      count_d = '0;
    end else if (level_q && pulse_tick && (count_q != LongMax)) begin
      count_d = count_q + CountW'(1);
      press_d = (count_d == LongMax);
    end
    held_d = level_d & (held_q | press_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      shift_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
      press_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bouncing};
      if (pulse_tick) begin
        shift_q <= {shift_q[DEPTH-2:0], sync};
      end
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
      count_q <= count_d;
      press_q <= press_d;
      held_q  <= held_d;
    end
  end

  assign debounced  = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign long_press = press_q;
  assign long_held  = held_q;

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: independent channels sharing one sample tick strobe.
module debouncer_multi
  import debouncer_multi_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DEPTH       = DEBOUNCE_DEPTH_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LONG_TICKS  = LONG_TICKS_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                PULSE_TICK,
  input  logic [CHANNELS-1:0] BOUNCING,
  output logic [CHANNELS-1:0] DEBOUNCED,
  output logic [CHANNELS-1:0] RISE,
  output logic [CHANNELS-1:0] FALL,
  output logic [CHANNELS-1:0] LONG_PRESS,
  output logic [CHANNELS-1:0] LONG_HELD
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .DEPTH      (DEPTH),
      .SYNC_STAGES(SYNC_STAGES),
      .LONG_TICKS (LONG_TICKS)
    ) u_chan (
      .clk       (CLK),
      .reset     (RESET),
      .pulse_tick(PULSE_TICK),
      .bouncing  (BOUNCING[i]),
      .debounced (DEBOUNCED[i]),
      .rise      (RISE[i]),
      .fall      (FALL[i]),
      .long_press(LONG_PRESS[i]),
      .long_held (LONG_HELD[i])
    );
  end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
Parametrised, multi-channel successor to the single-input 5 ms debouncer.
- Each channel: synchronises an asynchronous bouncing input, qualifies it over DEPTH consecutive tick samples, and holds a hysteretic debounced level.
- Adds per-channel rise/fall event pulses and long-press detection.
- Sits between board-level switch/button pins and the control logic.
- Consumes the shared PULSE_TICK strobe from the timers block.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- DEPTH, 5, consecutive equal tick samples required to change state (>=2).
- SYNC_STAGES, 2, flip-flop synchroniser stages per input (>=2).
- LONG_TICKS, 200, ticks of continuous debounced-high before long-press fires (>=1).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- PULSE_TICK  in  1  one-CLK-wide sample strobe from timers (e.g. 5 ms).
- BOUNCING  in  CHANNELS  raw asynchronous inputs.
- DEBOUNCED  out  CHANNELS  qualified levels.
- RISE  out  CHANNELS  one-cycle pulse when DEBOUNCED[i] goes 0->1.
- FALL  out  CHANNELS  one-cycle pulse when DEBOUNCED[i] goes 1->0.
- LONG_PRESS  out  CHANNELS  one-cycle pulse when the long-press threshold is reached.
- LONG_HELD  out  CHANNELS  level; high from the LONG_PRESS pulse until DEBOUNCED[i] falls.

Behaviour:
- Single clock domain: everything is on CLK posedge. RESET is synchronous, active-high, and overrides all other inputs.
- Reset values: synchroniser flops 0, shift registers 0, counters 0, all outputs 0.
- Synchroniser
  - SYNC_STAGES-deep flop chain per channel, clocked every CLK, independent of PULSE_TICK.
  - Its output is sync[i].
- Sample shift register
  - DEPTH bits per channel.
  - Shifts in sync[i] at the LSB only on cycles where PULSE_TICK=1; otherwise it holds.
- Debounced state, evaluated every CLK on the registered shift register:
  - all ones -> DEBOUNCED=1;
  - all zeros -> DEBOUNCED=0;
  - mixed -> hold (hysteresis).
- Latency: DEBOUNCED changes one CLK after the shift register first becomes uniform.
  - Input stable from cycle t: synced by t+SYNC_STAGES.
  - Then DEPTH ticks are needed.
  - DEBOUNCED flips 1 CLK after the DEPTH-th qualifying tick.
- RISE/FALL
  - Registered, asserted in the same cycle DEBOUNCED changes, deasserted the next cycle.
  - Never both high on one channel.
- Long-press counter
  - Width $clog2(LONG_TICKS+1).
  - Cleared whenever DEBOUNCED[i]=0.
  - While DEBOUNCED[i]=1, increments on PULSE_TICK and saturates at LONG_TICKS.
  - LONG_PRESS[i] pulses exactly once, in the cycle the counter becomes LONG_TICKS.
  - LONG_HELD[i] sets in that same cycle.
- Simultaneous events
  - Tick in the cycle DEBOUNCED rises: the counter does not count it; counting starts from the next tick.
  - Tick in the cycle DEBOUNCED falls: the counter clears and LONG_HELD clears in the same cycle FALL pulses.
- A release before LONG_TICKS produces no LONG_PRESS. A re-press restarts the count from 0.
- Channel independence: no cross-channel interaction; simultaneous activity on all channels is legal.
- Reset mid-operation clears all state; no event pulses are emitted due to reset.
- PULSE_TICK held high continuously is legal: it samples every CLK.

Decomposition:
- Shared package: default constants DEBOUNCE_DEPTH_DEFAULT=5 and LONG_TICKS_DEFAULT=200 for reuse by the timers and top level. No typedefs needed.
- One sub-module debounce_channel handles a single channel: synchroniser, shift register, level, edge pulses, long counter.
- debouncer_multi instantiates CHANNELS copies in a generate loop and shares PULSE_TICK.

Test Plan:
All scenarios use CHANNELS=4, DEPTH=5, SYNC_STAGES=2, LONG_TICKS=8, and PULSE_TICK every 10 CLK.
1. Clean press
   - Stimulus: BOUNCING[0]=1 held.
   - Required: DEBOUNCED[0] rises 1 CLK after the 5th tick that samples sync=1. RISE[0] is high exactly 1 cycle. Other channels stay 0.
2. Bounce rejection
   - Stimulus: BOUNCING[1] toggles every 13 CLK for 200 CLK, then is held 0.
   - Required: DEBOUNCED[1] stays 0. No RISE or FALL pulses.
3. Hysteresis
   - Stimulus: channel 2 debounced high, then one glitch low lasting 1 tick period.
   - Required: DEBOUNCED[2] remains 1 and no FALL pulse; a low held for 5 ticks produces FALL[2] once.
4. Long press
   - Stimulus: channel 3 held high.
   - Required: LONG_PRESS[3] pulses once on the 8th tick after RISE, and LONG_HELD[3]=1 until release. Releasing clears LONG_HELD[3] in the FALL cycle.
5. Short press
   - Stimulus: channel 0 released after 7 ticks high.
   - Required: no LONG_PRESS. A re-press counts from 0 and fires after 8 more ticks.
6. Reset mid-operation
   - Stimulus: RESET asserted for 1 CLK while all channels are debounced high with counters at 5.
   - Required: next cycle all outputs are 0, no FALL pulses, and re-qualification needs the full 5 ticks.
